// File: rtl/vga_pkg.sv
// Shared VGA timing package: default 1280x800 timing, total derivation and sync polarities.
// Sync polarities are shared with the game logic so both agree on what "asserted" means.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 1280;
  localparam int H_FP_DEF     = 64;
  localparam int H_SYNC_DEF   = 136;
  localparam int H_BP_DEF     = 200;
  localparam int V_ACTIVE_DEF = 800;
  localparam int V_FP_DEF     = 1;
  localparam int V_SYNC_DEF   = 3;
  localparam int V_BP_DEF     = 24;

  localparam logic HS_ACTIVE = 1'b0;
  localparam logic VS_ACTIVE = 1'b1;

  typedef logic [10:0] hcnt_t;
  typedef logic [9:0]  vcnt_t;
  typedef logic [3:0]  color_t;

  typedef struct packed {
    color_t r;
    color_t g;
    color_t b;
  } rgb_t;

  // Totals are formed at 12 bits so the largest legal sums cannot wrap.
  function automatic logic [11:0] calcTotal(input int active, input int fp,
                                            input int sync, input int bp);
    return 12'(active + fp + sync + bp);
  endfunction

  localparam logic [11:0] H_TOTAL_DEF = calcTotal(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam logic [11:0] V_TOTAL_DEF = calcTotal(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_if.sv
// Bundle between the pixel-colour generator and the VGA output stage.
// master = vga_out side (drives position and DAC signals), slave = colour generator / DAC side.
interface vga_if;
  import vga_pkg::*;

  color_t draw_r;
  color_t draw_g;
  color_t draw_b;
  hcnt_t  draw_x;
  vcnt_t  draw_y;
  color_t vga_r;
  color_t vga_g;
  color_t vga_b;
  logic   vga_hs;
  logic   vga_vs;
  logic   frame_tick;

  modport master (
    input  draw_r, draw_g, draw_b,
    output draw_x, draw_y, vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_tick
  );

  modport slave (
    output draw_r, draw_g, draw_b,
    input  draw_x, draw_y, vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_tick
  );

endinterface

// File: rtl/vga_ctr.sv
// Horizontal/vertical raster counter pair with end-of-line and end-of-frame wrap flags.
module vga_ctr
  import vga_pkg::*;
#(
  parameter logic [11:0] H_TOTAL = H_TOTAL_DEF,
  parameter logic [11:0] V_TOTAL = V_TOTAL_DEF
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_en,
  output hcnt_t o_hCnt,
  output vcnt_t o_vCnt,
  output logic  o_hWrap,
  output logic  o_vWrap
);

  localparam hcnt_t H_LAST = hcnt_t'(H_TOTAL - 12'd1);
  localparam vcnt_t V_LAST = vcnt_t'(V_TOTAL - 12'd1);

  hcnt_t r_hCnt;
  vcnt_t r_vCnt;
  logic  w_hWrap;
  logic  w_vWrap;

  assign w_hWrap = (r_hCnt == H_LAST);
  assign w_vWrap = w_hWrap && (r_vCnt == V_LAST);

  // Both counters return to zero on the same edge at end of frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hCnt <= '0;
      r_vCnt <= '0;
    end else if (i_en) begin
      if (w_hWrap) begin
        r_hCnt <= '0;
        r_vCnt <= w_vWrap ? '0 : r_vCnt + 10'd1;
      end else begin
        r_hCnt <= r_hCnt + 11'd1;
      end
    end
  end

  assign o_hCnt  = r_hCnt;
  assign o_vCnt  = r_vCnt;
  assign o_hWrap = w_hWrap;
  assign o_vWrap = w_vWrap;

endmodule

// File: rtl/vga_out.sv
// VGA output stage: raster counters, stage-0 decode, and one registered stage to the DAC
// so colour, syncs and frame_tick leave the block aligned.
module vga_out
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input logic  clk,
  input logic  rst_n,
  vga_if.master bus
);

  localparam logic [11:0] H_TOTAL  = calcTotal(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam logic [11:0] V_TOTAL  = calcTotal(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [11:0] H_ACT12  = 12'(H_ACTIVE);
  localparam logic [11:0] H_SS12   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SE12   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_ACT12  = 12'(V_ACTIVE);
  localparam logic [11:0] V_SS12   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SE12   = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic  r_run;
  hcnt_t w_hCnt;
  vcnt_t w_vCnt;
  logic  w_hWrap;
  logic  w_vWrap;
  logic [11:0] w_h12;
  logic [11:0] w_v12;
  logic  w_active;
  logic  w_hSync;
  logic  w_vSync;
  logic  w_frameStart;
  rgb_t  r_rgb;
  logic  r_hs;
  logic  r_vs;
  logic  r_frameTick;

  // First edge after reset release presents (0,0) to stage 0 before counting starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_run <= 1'b0;
    else        r_run <= 1'b1;
  end

  vga_ctr #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (r_run),
    .o_hCnt  (w_hCnt),
    .o_vCnt  (w_vCnt),
    .o_hWrap (w_hWrap),
    .o_vWrap (w_vWrap)
  );

  // A vertical wrap without the matching horizontal wrap would break the raster.
  always_comb assert (!w_vWrap || w_hWrap);

  assign w_h12        = {1'b0, w_hCnt};
  assign w_v12        = {2'b00, w_vCnt};
  assign w_active     = (w_h12 < H_ACT12) && (w_v12 < V_ACT12);
  assign w_hSync      = (w_h12 >= H_SS12) && (w_h12 < H_SE12);
  assign w_vSync      = (w_v12 >= V_SS12) && (w_v12 < V_SE12);
  assign w_frameStart = (w_hCnt == '0) && (w_v12 == V_ACT12);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb       <= '0;
      r_hs        <= ~HS_ACTIVE;
      r_vs        <= ~VS_ACTIVE;
      r_frameTick <= 1'b0;
    end else begin
      r_rgb       <= w_active ? rgb_t'({bus.draw_r, bus.draw_g, bus.draw_b}) : '0;
      r_hs        <= w_hSync ? HS_ACTIVE : ~HS_ACTIVE;
      r_vs        <= w_vSync ? VS_ACTIVE : ~VS_ACTIVE;
      r_frameTick <= w_frameStart;
    end
  end

  assign bus.draw_x     = w_hCnt;
  assign bus.draw_y     = w_vCnt;
  assign bus.vga_r      = r_rgb.r;
  assign bus.vga_g      = r_rgb.g;
  assign bus.vga_b      = r_rgb.b;
  assign bus.vga_hs     = r_hs;
  assign bus.vga_vs     = r_vs;
  assign bus.frame_tick = r_frameTick;

endmodule

// File: tb/tb_vga_out.sv
// Bench for vga_out: default-timing instance and a small-timing instance run side by side
// against a raster model derived from elapsed clocks since reset release.
module tb_vga_out;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vga_if busA ();
  vga_if busB ();

  vga_out dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busA)
  );

  vga_out #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1)
  ) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busB)
  );

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        hs;
    logic        vs;
    logic        ft;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int n = 0;
  logic [11:0] colA;
  logic [11:0] colB;
  int hsLowA = 0;
  int vsHighB = 0;
  int ticksB = 0;
  int ticksA = 0;

  // Sample taken after the n-th edge since release: counters sit at raster index n-1
  // (the first edge holds (0,0)); registered outputs show the stage-0 state one index earlier.
  function automatic exp_t refModel(input int nEdge, input int ha, input int hf, input int hsw,
                                    input int hb, input int va, input int vf, input int vsw,
                                    input int vb, input logic [11:0] col);
    exp_t e;
    int ht = ha + hf + hsw + hb;
    int vt = va + vf + vsw + vb;
    int p = nEdge - 1;
    int q = (p > 0) ? p - 1 : 0;
    int qx = q % ht;
    int qy = (q / ht) % vt;
    logic act = (qx < ha) && (qy < va);
    e.x  = 11'(p % ht);
    e.y  = 10'((p / ht) % vt);
    e.r  = act ? col[11:8] : 4'h0;
    e.g  = act ? col[7:4]  : 4'h0;
    e.b  = act ? col[3:0]  : 4'h0;
    e.hs = !((qx >= ha + hf) && (qx < ha + hf + hsw));
    e.vs = (qy >= va + vf) && (qy < va + vf + vsw);
    e.ft = (qx == 0) && (qy == va);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [10:0] obs, input logic [10:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, expv);
    end
  endtask

  task automatic applyStimulus(input bit constCol);
    colA = constCol ? 12'hFF0 : 12'($urandom);
    colB = 12'($urandom);
    busA.draw_r = colA[11:8];
    busA.draw_g = colA[7:4];
    busA.draw_b = colA[3:0];
    busB.draw_r = colB[11:8];
    busB.draw_g = colB[7:4];
    busB.draw_b = colB[3:0];
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_A_x"},  busA.draw_x, 11'd0);
    checkOutput({tag, "_A_y"},  11'(busA.draw_y), 11'd0);
    checkOutput({tag, "_A_rgb"}, 11'({busA.vga_r, busA.vga_g, busA.vga_b}), 11'd0);
    checkOutput({tag, "_A_hs"}, 11'(busA.vga_hs), 11'd1);
    checkOutput({tag, "_A_vs"}, 11'(busA.vga_vs), 11'd0);
    checkOutput({tag, "_A_ft"}, 11'(busA.frame_tick), 11'd0);
    checkOutput({tag, "_B_x"},  busB.draw_x, 11'd0);
    checkOutput({tag, "_B_hs"}, 11'(busB.vga_hs), 11'd1);
    checkOutput({tag, "_B_vs"}, 11'(busB.vga_vs), 11'd0);
    checkOutput({tag, "_B_ft"}, 11'(busB.frame_tick), 11'd0);
  endtask

  task automatic stepAndCheck(input bit constCol);
    exp_t eA;
    exp_t eB;
    @(posedge clk);
    n++;
    @(negedge clk);
    eA = refModel(n, 1280, 64, 136, 200, 800, 1, 3, 24, colA);
    eB = refModel(n, 8, 2, 2, 2, 4, 1, 1, 1, colB);
    checkOutput("A_x",  busA.draw_x, eA.x);
    checkOutput("A_y",  11'(busA.draw_y), 11'(eA.y));
    checkOutput("A_r",  11'(busA.vga_r), 11'(eA.r));
    checkOutput("A_g",  11'(busA.vga_g), 11'(eA.g));
    checkOutput("A_b",  11'(busA.vga_b), 11'(eA.b));
    checkOutput("A_hs", 11'(busA.vga_hs), 11'(eA.hs));
    checkOutput("A_vs", 11'(busA.vga_vs), 11'(eA.vs));
    checkOutput("A_ft", 11'(busA.frame_tick), 11'(eA.ft));
    checkOutput("B_x",  busB.draw_x, eB.x);
    checkOutput("B_y",  11'(busB.draw_y), 11'(eB.y));
    checkOutput("B_rgb", 11'({busB.vga_r, busB.vga_g, busB.vga_b}), 11'({eB.r, eB.g, eB.b}));
    checkOutput("B_hs", 11'(busB.vga_hs), 11'(eB.hs));
    checkOutput("B_vs", 11'(busB.vga_vs), 11'(eB.vs));
    checkOutput("B_ft", 11'(busB.frame_tick), 11'(eB.ft));
    if (n >= 2 && n <= 1681 && busA.vga_hs == 1'b0) hsLowA++;
    if (n >= 2 && n <= 99 && busB.vga_vs == 1'b1) vsHighB++;
    if (n <= 294 && busB.frame_tick == 1'b1) ticksB++;
    if (busA.frame_tick == 1'b1) ticksA++;
    applyStimulus(constCol);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0);
    repeat (3) @(negedge clk);
    checkResetValues("rstHold");

    // Release between edges; line 2 onward of the default instance sees constant F,F,0.
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 5741; i++) stepAndCheck(n >= 3360);

    checkOutput("A_hsLowLen",  11'(hsLowA), 11'd136);
    checkOutput("B_vsHighLen", 11'(vsHighB), 11'd14);
    checkOutput("B_tick3Frames", 11'(ticksB), 11'd3);
    checkOutput("A_midX", busA.draw_x, 11'd700);
    checkOutput("A_midY", 11'(busA.draw_y), 11'd3);

    // Mid-frame reset between edges must clear outputs without waiting for a clock.
    #2 rst_n = 1'b0;
    #1 checkResetValues("asyncRst");
    repeat (5) begin
      @(negedge clk);
      checkResetValues("rstLow");
    end
    rst_n = 1'b1;
    n = 0;
    ticksA = 0;
    for (int i = 0; i < 400; i++) stepAndCheck(1'b1);
    checkOutput("A_noTickAfterRst", 11'(ticksA), 11'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
